mpx_target_responder: RTL
=========================

# mpx_target_responder

Target-side responder for the MPC7410 60x/MPX processor bus, i.e. the memory-controller end that a Tsi107-style host bridge presents to the CPU. Accepts one address tenure at a time and answers it with AACK. Completes the data tenure (single-beat or 4-beat burst) with TA against an internal doubleword memory, or with TEA on an out-of-window address. Instantiated inside design_1 opposite the processor bus master, with the system testbench clock driving it.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base of the decoded window.
- DEPTH, 256: memory size in 64-bit doublewords; power of two, window = DEPTH*8 bytes.
- AACK_WAIT, 1: idle cycles between TS sample and AACK (0..7).
- DATA_WAIT, 0: idle cycles before each TA beat (0..7).

Ports:
- clk  in  1  bus clock; all activity on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ts  in  1  transfer start, active-high, one cycle.
- addr  in  32  transfer address, valid with ts.
- tt  in  5  transfer type, valid with ts; tt[3]=1 read, 0 write; tt[3:1]==3'b000 address-only.
- tbst  in  1  burst (4 beats, 32 bytes) when 1, valid with ts.
- tsiz  in  3  single-beat size in bytes: 0 means 8, 1..4 literal; ignored when tbst=1.
- din  in  64  write data, sampled on TA edges.
- dout  out  64  read data, valid only while ta=1, else 0.
- aack  out  1  address acknowledge, one-cycle pulse.
- ta  out  1  transfer acknowledge, one pulse per beat.
- tea  out  1  transfer error, one-cycle pulse, terminates tenure.
- busy  out  1  high from the cycle after ts until the last ta/tea/aack cycle inclusive.

## Operation
- FSM: IDLE -> AWAIT -> ACK -> (DWAIT -> BEAT)* -> IDLE; ERR replaces the DWAIT/BEAT path on decode error.
- IDLE: ts=1 latches addr/tt/tbst/tsiz and moves to AWAIT. AWAIT lasts AACK_WAIT cycles and is skipped when AACK_WAIT=0.
- ACK: aack=1 for one cycle. An address-only transaction returns to IDLE here.
- Decode error when the address is outside [BASE_ADDR, BASE_ADDR+DEPTH*8), or when a single beat crosses a doubleword boundary (addr[2:0]+size>8). Error path: ACK -> ERR, tea=1 for one cycle, no memory access.
- Burst: 4 beats in critical-word-first order. Start doubleword = addr[4:3], then increment mod 4 within the 32-byte line. Example: addr[4:3]=2 gives 2,3,0,1.
- Single beat: byte lanes addr[2:0] .. addr[2:0]+size-1, with big-endian lane 0 = din[63:56]. A write updates only those lanes. A read returns the full doubleword.
- Memory index = (addr-BASE_ADDR)[3+:log2(DEPTH)]. Memory contents are not reset.
- ts while busy=1 is ignored. No address pipelining.

## Timing
- Reset values: aack=0, ta=0, tea=0, busy=0, dout=0, FSM=IDLE. Reset mid-tenure aborts it immediately; a partially written burst keeps the beats already written.
- With ts high in cycle k:
  - aack is high in cycle k+1+AACK_WAIT.
  - the first ta or tea is high in cycle k+2+AACK_WAIT+DATA_WAIT.
  - each following beat comes 1+DATA_WAIT cycles later.
- Zero-wait burst: aack at k+1, ta at k+2..k+5, busy low at k+6, and a new ts is accepted at k+6.
- aack and ta are never high in the same cycle.
- A write memory update is visible to a read whose ta occurs at least one cycle after the write's ta.

## Configuration
- MPX_RESP_PARITY_EN defined adds three ports:
  - dpin in 8 and dpout out 8: odd parity per byte lane, dpout valid with ta, else 0.
  - dperr out 1: one-cycle pulse with the offending write ta when any enabled lane's dpin mismatches. The write is still performed.
- Undefined: the three ports and the parity logic are absent. All other behaviour is identical.

## Test plan
- Reset, then single write of 8 bytes: addr=0x10, din=0x0123456789ABCDEF, defaults. Expect aack at k+2, ta at k+3. A single read of 0x10 then returns 0x0123456789ABCDEF with ta.
- Single 2-byte write at addr=0x16, din lanes 6..7=0xBEEF. Read of 0x10 returns 0x012345678 9ABBEEF with bytes 0..5 unchanged, i.e. 0x0123456789ABBEEF.
- Burst read at addr=0x30 (addr[4:3]=2) after seeding doublewords 0x20..0x38 with 1,2,3,4. Expect four consecutive ta with dout = 3,4,1,2.
- Out-of-window burst read with addr=BASE_ADDR+DEPTH*8. Expect aack, then one tea cycle, no ta, busy low immediately after.
- Address-only (tt=5'b00000), plus a second ts during a burst. Expect aack only on the first. The second ts is ignored: no extra aack, memory unchanged.
- Assert rst after the second ta of a burst write. Outputs go 0 at once. The first two doublewords are written, the last two unchanged. The next ts is serviced normally.

Source files
------------

// File: rtl/mpx_target_responder.sv
// mpx_target_responder: target end of a 60x/MPX processor bus. Accepts one
// address tenure at a time, answers with AACK, then completes the data tenure
// with TA beats (single or 4-beat critical-word-first burst) against an
// internal doubleword memory, or with one TEA on a decode error.
// Optional feature macro: MPX_RESP_PARITY_EN adds per-byte odd data parity
// (dpin, dpout, dperr). DEPTH must be a power of two and at least 4.
module mpx_target_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          AACK_WAIT = 1,
  parameter int          DATA_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ts,
  input  logic [31:0] addr,
  input  logic [4:0]  tt,
  input  logic        tbst,
  input  logic [2:0]  tsiz,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        aack,
  output logic        ta,
  output logic        tea,
  output logic        busy
`ifdef MPX_RESP_PARITY_EN
  ,
  input  logic [7:0]  dpin,
  output logic [7:0]  dpout,
  output logic        dperr
`endif
);

  localparam int          IW     = $clog2(DEPTH);
  localparam logic [32:0] WINDOW = 33'(DEPTH) * 33'd8;

  typedef enum logic [2:0] {S_IDLE, S_AWAIT, S_ACK, S_DWAIT, S_BEAT, S_ERR} state_t;

  state_t          state;
  logic [2:0]      cnt_reg;
  logic [1:0]      beat_reg;
  logic [IW-1:0]   idx_reg;
  logic [7:0]      lane_en_reg;
  logic            write_reg;
  logic            burst_reg;
  logic            aonly_reg;
  logic            err_reg;

  // Address decode on the live bus inputs, latched when ts is accepted.
  logic [31:0] offset;
  logic [3:0]  size;
  logic        in_window;
  logic        crosses;
  logic [7:0]  lanes;

  assign offset    = addr - BASE_ADDR;
  assign size      = (tsiz == 3'd0) ? 4'd8 : {1'b0, tsiz};
  assign in_window = (addr >= BASE_ADDR) && ({1'b0, offset} < WINDOW);
  assign crosses   = !tbst && (({1'b0, addr[2:0]} + size) > 4'd8);

  // Big-endian byte lane gi (din[63:56] is lane 0) is enabled when it lies in
  // addr[2:0] .. addr[2:0]+size-1; bursts always move full doublewords.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign lanes[gi] = tbst ||
        ((4'(gi) >= {1'b0, addr[2:0]}) && (4'(gi) < ({1'b0, addr[2:0]} + size)));
    end
  endgenerate

  // Tenure sequencer with registered aack/ta/tea/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt_reg     <= 3'd0;
      beat_reg    <= 2'd0;
      idx_reg     <= '0;
      lane_en_reg <= 8'd0;
      write_reg   <= 1'b0;
      burst_reg   <= 1'b0;
      aonly_reg   <= 1'b0;
      err_reg     <= 1'b0;
      aack        <= 1'b0;
      ta          <= 1'b0;
      tea         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      aack <= 1'b0;
      ta   <= 1'b0;
      tea  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ts) begin
            idx_reg     <= offset[3 +: IW];
            lane_en_reg <= lanes;
            write_reg   <= !tt[3];
            burst_reg   <= tbst;
            aonly_reg   <= (tt[3:1] == 3'b000);
            err_reg     <= !in_window || crosses;
            beat_reg    <= 2'd0;
            busy        <= 1'b1;
            if (AACK_WAIT == 0) begin
              state <= S_ACK;
              aack  <= 1'b1;
            end else begin
              state   <= S_AWAIT;
              cnt_reg <= 3'(AACK_WAIT - 1);
            end
          end
        end
        S_AWAIT: begin
          if (cnt_reg == 3'd0) begin
            state <= S_ACK;
            aack  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        S_ACK: begin
          if (aonly_reg) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (DATA_WAIT != 0) begin
            state   <= S_DWAIT;
            cnt_reg <= 3'(DATA_WAIT - 1);
          end else if (err_reg) begin
            state <= S_ERR;
            tea   <= 1'b1;
          end else begin
            state <= S_BEAT;
            ta    <= 1'b1;
          end
        end
        S_DWAIT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else if (err_reg) begin
            state <= S_ERR;
            tea   <= 1'b1;
          end else begin
            state <= S_BEAT;
            ta    <= 1'b1;
          end
        end
        S_BEAT: begin
          if (!burst_reg || beat_reg == 2'd3) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            beat_reg <= beat_reg + 2'd1;
            if (DATA_WAIT == 0) begin
              ta <= 1'b1;
            end else begin
              state   <= S_DWAIT;
              cnt_reg <= 3'(DATA_WAIT - 1);
            end
          end
        end
        S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Burst beats wrap within the 32-byte line. The read port is addressed one
  // beat ahead while a beat is on the bus so back-to-back beats have data ready.
  logic [1:0]    rd_beat;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          we;
  logic [63:0]   rd_word;

  assign rd_beat = (state == S_BEAT) ? beat_reg + 2'd1 : beat_reg;
  assign wr_idx  = {idx_reg[IW-1:2], idx_reg[1:0] + beat_reg};
  assign rd_idx  = {idx_reg[IW-1:2], idx_reg[1:0] + rd_beat};
  assign we      = ta && write_reg;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_bank
      logic [7:0] bank [DEPTH];
      logic [7:0] rd_byte;
      // One byte-wide bank per lane: lane-masked write, registered read.
      always_ff @(posedge clk) begin
        if (we && lane_en_reg[gi]) begin
          bank[wr_idx] <= din[8*(7-gi) +: 8];
        end
        rd_byte <= bank[rd_idx];
      end
      assign rd_word[8*(7-gi) +: 8] = rd_byte;
    end
  endgenerate

  assign dout = ta ? rd_word : 64'd0;

`ifdef MPX_RESP_PARITY_EN
  // Odd parity per byte; dp bit j covers din/dout[8j+7:8j] (big-endian lane 7-j).
  logic [7:0] lane_bad;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign dpout[gi]    = ta ? ~^dout[8*gi +: 8] : 1'b0;
      assign lane_bad[gi] = lane_en_reg[7-gi] && (dpin[gi] != ~^din[8*gi +: 8]);
    end
  endgenerate
  assign dperr = we && (|lane_bad);
`endif

  // Transfer-type bits outside tt[3:1] and the high offset bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{tt[4], tt[0], offset};

endmodule
